sram_rr_burst_ctrl: RTL and testbench

SRAM_RR_BURST_CTRL -- requirements
Module: sram_rr_burst_ctrl

---
 rtl/sram_rr_burst_ctrl_if.sv | 37 +++
 rtl/sram_rr_burst_ctrl.sv | 119 +++++++++++
 tb/tb_sram_rr_burst_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rr_burst_ctrl_if.sv
// Requester-side and SRAM-side signal bundle for the two-port round-robin burst controller.
// The slave modport is the controller's view; master is the view of its environment.
interface sram_rr_burst_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              REQ0, REQ1;
  logic              WE0, WE1;
  logic [ADDR_W-1:0] ADDR0, ADDR1;
  logic [LEN_W-1:0]  LEN0, LEN1;
  logic [DATA_W-1:0] WDATA0, WDATA1;
  logic              GNT0, GNT1;
  logic              BEAT0, BEAT1;
  logic              RVALID0, RVALID1;
  logic              RLAST;
  logic [DATA_W-1:0] RDATA;
  logic              BUSY;
  logic              SRAM_CEB, SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_D;
  logic [7:0]        SRAM_Q0, SRAM_Q1, SRAM_Q2, SRAM_Q3;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, LEN0, LEN1, WDATA0, WDATA1,
    input  SRAM_Q0, SRAM_Q1, SRAM_Q2, SRAM_Q3,
    output GNT0, GNT1, BEAT0, BEAT1, RVALID0, RVALID1, RLAST, RDATA, BUSY,
    output SRAM_CEB, SRAM_WEB, SRAM_A, SRAM_D
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, LEN0, LEN1, WDATA0, WDATA1,
    output SRAM_Q0, SRAM_Q1, SRAM_Q2, SRAM_Q3,
    input  GNT0, GNT1, BEAT0, BEAT1, RVALID0, RVALID1, RLAST, RDATA, BUSY,
    input  SRAM_CEB, SRAM_WEB, SRAM_A, SRAM_D
  );
endinterface

// File: rtl/sram_rr_burst_ctrl.sv
// Round-robin two-requester SRAM burst controller: grant in IDLE, first beat next cycle, read data one cycle after each beat.
// No backpressure: a granted burst runs LEN+1 consecutive beats; losing requesters simply wait in IDLE for a grant.
module sram_rr_burst_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input logic                 CLK,
  input logic                 RSTN,
  sram_rr_burst_ctrl_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic              rvalid0_q, rvalid1_q, rlast_q;

  logic              pick;
  logic              gnt0, gnt1, beat0, beat1;
  logic              ceb, web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;  // requester 1 counts as last served, so 0 wins the first tie
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      id_q      <= id_d;
      last_q    <= last_d;
      rvalid0_q <= (state_q == BURST) && !we_q && !id_q;
      rvalid1_q <= (state_q == BURST) && !we_q && id_q;
      rlast_q   <= (state_q == BURST) && !we_q && (cnt_q == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    id_d    = id_q;
    last_d  = last_q;
    pick    = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    beat0   = 1'b0;
    beat1   = 1'b0;
    ceb     = 1'b1;
    web     = 1'b1;
    sram_a  = '0;
    sram_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          pick    = (bus.REQ0 && bus.REQ1) ? !last_q : bus.REQ1;
          gnt0    = !pick;
          gnt1    = pick;
          id_d    = pick;
          last_d  = pick;
          addr_d  = pick ? bus.ADDR1 : bus.ADDR0;
          cnt_d   = pick ? bus.LEN1  : bus.LEN0;
          we_d    = pick ? bus.WE1   : bus.WE0;
          state_d = BURST;
        end
      end
      BURST: begin
        ceb    = 1'b0;
        web    = !we_q;
        sram_a = addr_q;
        beat0  = !id_q;
        beat1  = id_q;
        if (we_q) begin
          sram_d = id_q ? bus.WDATA1 : bus.WDATA0;
        end
        addr_d = addr_q + ADDR_W'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are combinational from REQ, so gate them to stay silent while reset is held.
  assign bus.GNT0     = gnt0 && RSTN;
  assign bus.GNT1     = gnt1 && RSTN;
  assign bus.BEAT0    = beat0;
  assign bus.BEAT1    = beat1;
  assign bus.BUSY     = (state_q == BURST);
  assign bus.SRAM_CEB = ceb;
  assign bus.SRAM_WEB = web;
  assign bus.SRAM_A   = sram_a;
  assign bus.SRAM_D   = sram_d;
  assign bus.RVALID0  = rvalid0_q;
  assign bus.RVALID1  = rvalid1_q;
  assign bus.RLAST    = rlast_q;
  assign bus.RDATA    = (rvalid0_q || rvalid1_q)
                      ? DATA_W'({bus.SRAM_Q0, bus.SRAM_Q1, bus.SRAM_Q2, bus.SRAM_Q3}) : '0;

endmodule

// File: tb/tb_sram_rr_burst_ctrl.sv
// Randomized bench for sram_rr_burst_ctrl with a behavioural SRAM and a reference memory model.
module tb_sram_rr_burst_ctrl;

  logic CLK = 1'b0;
  logic RSTN;
  int   n_tests = 0;
  int   n_fail  = 0;

  sram_rr_burst_ctrl_if #(.ADDR_W(12), .DATA_W(32), .LEN_W(4)) bus ();

  sram_rr_burst_ctrl #(.ADDR_W(12), .DATA_W(32), .LEN_W(4)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Synchronous SRAM: one-cycle read latency, write on CEB=0/WEB=0.
  logic [31:0] sram_mem [0:4095] = '{default: 32'h0};
  logic [31:0] sram_q = 32'h0;
  always @(posedge CLK) begin
    if (!bus.SRAM_CEB) begin
      if (!bus.SRAM_WEB) sram_mem[bus.SRAM_A] <= bus.SRAM_D;
      else               sram_q <= sram_mem[bus.SRAM_A];
    end
  end
  assign bus.SRAM_Q0 = sram_q[31:24];
  assign bus.SRAM_Q1 = sram_q[23:16];
  assign bus.SRAM_Q2 = sram_q[15:8];
  assign bus.SRAM_Q3 = sram_q[7:0];

  // Reference contents: what every address should hold after the bursts issued so far.
  logic [31:0] ref_mem [0:4095] = '{default: 32'h0};

  task automatic clear_inputs();
    bus.REQ0 = 0; bus.REQ1 = 0; bus.WE0 = 0; bus.WE1 = 0;
    bus.ADDR0 = '0; bus.ADDR1 = '0; bus.LEN0 = '0; bus.LEN1 = '0;
    bus.WDATA0 = '0; bus.WDATA1 = '0;
  endtask

  // One complete burst from a single requester, checked every cycle against the reference model.
  task automatic burst(input bit id, input bit we, input logic [11:0] addr,
                       input logic [3:0] len, input bit seq);
    logic [31:0] wd, exp_rd;
    logic [11:0] a;
    bit          exp_rv;
    @(posedge CLK); #1;
    bus.REQ0 = !id; bus.REQ1 = id;
    if (id) begin bus.WE1 = we; bus.ADDR1 = addr; bus.LEN1 = len; end
    else    begin bus.WE0 = we; bus.ADDR0 = addr; bus.LEN0 = len; end
    @(negedge CLK);
    n_tests++;
    if ({bus.GNT1, bus.GNT0, bus.BUSY, bus.RVALID1, bus.RVALID0} !== {id, !id, 3'b000}) begin
      n_fail++;
      $display("FAIL grant id=%0d: gnt=%b%b busy=%b rv=%b%b, required gnt=%b%b busy=0 rv=00",
               id, bus.GNT1, bus.GNT0, bus.BUSY, bus.RVALID1, bus.RVALID0, id, !id);
    end
    for (int k = 0; k <= int'(len); k++) begin
      @(posedge CLK); #1;
      bus.REQ0 = 1'($urandom); bus.REQ1 = 1'($urandom);
      bus.WE0 = 1'($urandom); bus.WE1 = 1'($urandom);
      bus.ADDR0 = 12'($urandom); bus.ADDR1 = 12'($urandom);
      bus.LEN0 = 4'($urandom); bus.LEN1 = 4'($urandom);
      wd = seq ? 32'(k) : $urandom;
      bus.WDATA0 = $urandom; bus.WDATA1 = $urandom;
      if (id) bus.WDATA1 = wd; else bus.WDATA0 = wd;
      @(negedge CLK);
      a = addr + 12'(k);
      n_tests++;
      if (bus.SRAM_CEB !== 1'b0 || bus.SRAM_WEB !== !we || bus.SRAM_A !== a ||
          {bus.BEAT1, bus.BEAT0} !== {id, !id} || bus.SRAM_D !== (we ? wd : 32'h0) ||
          bus.BUSY !== 1'b1 || {bus.GNT1, bus.GNT0} !== 2'b00) begin
        n_fail++;
        $display("FAIL beat %0d id=%0d we=%0d: ceb=%b web=%b a=%h beat=%b%b d=%h busy=%b gnt=%b%b, required a=%h d=%h",
                 k, id, we, bus.SRAM_CEB, bus.SRAM_WEB, bus.SRAM_A, bus.BEAT1, bus.BEAT0,
                 bus.SRAM_D, bus.BUSY, bus.GNT1, bus.GNT0, a, (we ? wd : 32'h0));
      end
      exp_rv = !we && (k > 0);
      exp_rd = exp_rv ? ref_mem[a - 12'd1] : 32'h0;
      n_tests++;
      if ({bus.RVALID1, bus.RVALID0} !== (exp_rv ? {id, !id} : 2'b00) ||
          bus.RLAST !== 1'b0 || bus.RDATA !== exp_rd) begin
        n_fail++;
        $display("FAIL rdata beat %0d: rv=%b%b rlast=%b rdata=%h, required rv=%b rlast=0 rdata=%h",
                 k, bus.RVALID1, bus.RVALID0, bus.RLAST, bus.RDATA, exp_rv, exp_rd);
      end
      if (we) ref_mem[a] = wd;
    end
    @(posedge CLK); #1;
    bus.REQ0 = 0; bus.REQ1 = 0;
    @(negedge CLK);
    a = addr + 12'(len);
    exp_rd = we ? 32'h0 : ref_mem[a];
    n_tests++;
    if (bus.BUSY !== 1'b0 || bus.SRAM_CEB !== 1'b1 || bus.SRAM_WEB !== 1'b1 ||
        bus.SRAM_A !== 12'h0 || bus.SRAM_D !== 32'h0 || {bus.BEAT1, bus.BEAT0} !== 2'b00 ||
        {bus.RVALID1, bus.RVALID0} !== (we ? 2'b00 : {id, !id}) ||
        bus.RLAST !== !we || bus.RDATA !== exp_rd) begin
      n_fail++;
      $display("FAIL burst end id=%0d we=%0d: busy=%b ceb=%b a=%h rv=%b%b rlast=%b rdata=%h, required rlast=%b rdata=%h",
               id, we, bus.BUSY, bus.SRAM_CEB, bus.SRAM_A, bus.RVALID1, bus.RVALID0,
               bus.RLAST, bus.RDATA, !we, exp_rd);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    RSTN = 1'b0;
    bus.REQ0 = 1; bus.REQ1 = 1;
    #3;
    n_tests++;
    if ({bus.GNT0, bus.GNT1, bus.BEAT0, bus.BEAT1, bus.RVALID0, bus.RVALID1, bus.RLAST, bus.BUSY} !== 8'h0 ||
        bus.SRAM_CEB !== 1'b1 || bus.SRAM_WEB !== 1'b1 || bus.SRAM_A !== 12'h0 ||
        bus.SRAM_D !== 32'h0 || bus.RDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL reset outputs: gnt=%b%b beat=%b%b rv=%b%b busy=%b ceb=%b a=%h rdata=%h, required all idle",
               bus.GNT1, bus.GNT0, bus.BEAT1, bus.BEAT0, bus.RVALID1, bus.RVALID0, bus.BUSY,
               bus.SRAM_CEB, bus.SRAM_A, bus.RDATA);
    end
    @(posedge CLK); #1;
    bus.REQ0 = 0; bus.REQ1 = 0;
    RSTN = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (bus.BUSY !== 1'b0 || bus.SRAM_CEB !== 1'b1 || {bus.GNT1, bus.GNT0} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle after reset: busy=%b ceb=%b gnt=%b%b, required 0 1 00",
               bus.BUSY, bus.SRAM_CEB, bus.GNT1, bus.GNT0);
    end
  endtask

  task automatic test_single_read();
    burst(1'b0, 1'b1, 12'h010, 4'd0, 1'b0);
    burst(1'b0, 1'b0, 12'h010, 4'd0, 1'b0);
  endtask

  task automatic test_wrap();
    burst(1'b1, 1'b1, 12'hFFE, 4'd3, 1'b0);
    burst(1'b0, 1'b0, 12'hFFE, 4'd3, 1'b0);
  endtask

  task automatic test_long_read();
    burst(1'b0, 1'b1, 12'h100, 4'd15, 1'b1);
    burst(1'b1, 1'b0, 12'h100, 4'd15, 1'b0);
  endtask

  task automatic test_contention();
    bit          own;
    int          ph;
    logic [3:0]  exp_ctl;
    logic [11:0] exp_a;
    RSTN = 1'b0;
    #2;
    bus.REQ0 = 1; bus.REQ1 = 1; bus.WE0 = 0; bus.WE1 = 0;
    bus.LEN0 = 4'd1; bus.LEN1 = 4'd1; bus.ADDR0 = 12'h200; bus.ADDR1 = 12'h300;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(posedge CLK); #1; end
      @(negedge CLK);
      ph  = c % 3;
      own = ((c / 3) % 2) == 1;
      exp_ctl = (ph == 0) ? {own, !own, 2'b00} : {2'b00, own, !own};
      exp_a   = (ph == 0) ? 12'h0 : ((own ? 12'h300 : 12'h200) + 12'(ph - 1));
      n_tests++;
      if ({bus.GNT1, bus.GNT0, bus.BEAT1, bus.BEAT0} !== exp_ctl || bus.SRAM_A !== exp_a) begin
        n_fail++;
        $display("FAIL contention cycle %0d: gnt=%b%b beat=%b%b a=%h, required gnt/beat=%b a=%h",
                 c, bus.GNT1, bus.GNT0, bus.BEAT1, bus.BEAT0, bus.SRAM_A, exp_ctl, exp_a);
      end
    end
    @(posedge CLK); #1;
    bus.REQ0 = 0; bus.REQ1 = 0;
    @(negedge CLK);
    n_tests++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL contention drain: busy=%b, required 0", bus.BUSY);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      burst(1'($urandom), 1'($urandom), 12'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int wait_cyc;
    burst(1'b0, 1'b1, 12'h400, 4'd15, 1'b1);
    @(posedge CLK); #1;
    bus.REQ0 = 1; bus.WE0 = 0; bus.ADDR0 = 12'h400; bus.LEN0 = 4'd15;
    @(negedge CLK);
    n_tests++;
    if ({bus.GNT1, bus.GNT0} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid-reset grant: gnt=%b%b, required 01", bus.GNT1, bus.GNT0);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      bus.REQ0 = 0;
      @(negedge CLK);
      n_tests++;
      if (bus.SRAM_A !== 12'h400 + 12'(k) || bus.BEAT0 !== 1'b1 || bus.SRAM_CEB !== 1'b0) begin
        n_fail++;
        $display("FAIL mid-reset beat %0d: a=%h beat0=%b ceb=%b, required a=%h 1 0",
                 k, bus.SRAM_A, bus.BEAT0, bus.SRAM_CEB, 12'h400 + 12'(k));
      end
    end
    #1 RSTN = 1'b0;
    #1;
    n_tests++;
    if ({bus.GNT0, bus.GNT1, bus.BEAT0, bus.BEAT1, bus.RVALID0, bus.RVALID1, bus.RLAST, bus.BUSY} !== 8'h0 ||
        bus.SRAM_CEB !== 1'b1 || bus.SRAM_WEB !== 1'b1 || bus.SRAM_A !== 12'h0 ||
        bus.SRAM_D !== 32'h0 || bus.RDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL async abort: beat=%b%b rv=%b%b rlast=%b busy=%b ceb=%b a=%h rdata=%h, required all idle",
               bus.BEAT1, bus.BEAT0, bus.RVALID1, bus.RVALID0, bus.RLAST, bus.BUSY,
               bus.SRAM_CEB, bus.SRAM_A, bus.RDATA);
    end
    @(posedge CLK); #1;
    RSTN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      n_tests++;
      if ({bus.RVALID1, bus.RVALID0} !== 2'b00 || bus.SRAM_CEB !== 1'b1 || bus.BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL post-abort cycle %0d: rv=%b%b ceb=%b busy=%b, required 00 1 0",
                 c, bus.RVALID1, bus.RVALID0, bus.SRAM_CEB, bus.BUSY);
      end
      @(posedge CLK); #1;
    end
    bus.REQ0 = 1; bus.REQ1 = 1; bus.WE0 = 0; bus.WE1 = 0;
    bus.LEN0 = 4'd0; bus.LEN1 = 4'd0; bus.ADDR0 = 12'h400; bus.ADDR1 = 12'h401;
    @(negedge CLK);
    n_tests++;
    if ({bus.GNT1, bus.GNT0} !== 2'b01) begin
      n_fail++;
      $display("FAIL first grant after abort: gnt=%b%b, required 01", bus.GNT1, bus.GNT0);
    end
    @(posedge CLK); #1;
    bus.REQ0 = 0; bus.REQ1 = 0;
    wait_cyc = 0;
    @(negedge CLK);
    while (bus.BUSY === 1'b1 && wait_cyc < 20) begin
      @(negedge CLK);
      wait_cyc++;
    end
    n_tests++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL drain timeout: busy=%b after %0d cycles, required 0", bus.BUSY, wait_cyc);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    clear_inputs();
    RSTN = 1'b0;
    test_reset();
    test_single_read();
    test_wrap();
    test_long_read();
    test_contention();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
